jtcop_gfx_romrsp: RTL

//  Responder end of the tile-layer ROM fetch handshake (rom_cs/rom_addr -> rom_data/rom_ok) used by the

---
 rtl/jtcop_gfx_romrsp.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/jtcop_gfx_romrsp.sv
`default_nettype none
// ============================================================================
// Module   : jtcop_gfx_romrsp
// Brief    : Three-slot tile ROM responder with a one-entry cache per slot,
//            refilled from a 16-bit SDRAM bank via round-robin arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module jtcop_gfx_romrsp #(
    parameter int             AW      = 17,
    parameter int             SAW     = 22,
    parameter logic [SAW-1:0] OFFSET0 = 22'h0,
    parameter logic [SAW-1:0] OFFSET1 = 22'h40000,
    parameter logic [SAW-1:0] OFFSET2 = 22'h80000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           slot0_cs,
    input  logic [AW-1:0]  slot0_addr,
    output logic [31:0]    slot0_dout,
    output logic           slot0_ok,
    input  logic           slot1_cs,
    input  logic [AW-1:0]  slot1_addr,
    output logic [31:0]    slot1_dout,
    output logic           slot1_ok,
    input  logic           slot2_cs,
    input  logic [AW-1:0]  slot2_addr,
    output logic [31:0]    slot2_dout,
    output logic           slot2_ok,
    output logic           sdram_req,
    output logic [SAW-1:0] sdram_addr,
    input  logic           sdram_ack,
    input  logic           data_rdy,
    input  logic [15:0]    data_read
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_W0   = 2'd2;
    localparam logic [1:0] S_W1   = 2'd3;

    logic [2:0]     w_cs;
    logic [AW-1:0]  w_addr [3];
    logic [AW-1:0]  r_tag  [3];
    logic [31:0]    r_data [3];
    logic [2:0]     r_valid, r_ok, w_hit, w_miss;

    logic [1:0]     r_state, w_state_nxt;
    logic [1:0]     r_ptr, r_slot, w_c1, w_c2, w_c3, w_pick;
    logic           w_any;
    logic [AW-1:0]  r_addr;
    logic [15:0]    r_low;
    logic           r_req;
    logic [SAW-1:0] r_sdaddr, w_base, w_sdaddr_nxt;

    assign w_cs      = {slot2_cs, slot1_cs, slot0_cs};
    assign w_addr[0] = slot0_addr;
    assign w_addr[1] = slot1_addr;
    assign w_addr[2] = slot2_addr;

    // Hit compares against the tag as it stands this cycle, so a refill
    // landing now only shows up as ok on the following clock.
    generate
        for (genvar i = 0; i < 3; i++) begin : g_slot
            assign w_hit[i]  = w_cs[i] & r_valid[i] & (w_addr[i] == r_tag[i]);
            assign w_miss[i] = w_cs[i] & ~w_hit[i];
        end
    endgenerate

    function automatic logic [1:0] f_next(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    // Round-robin: search starts at the slot after the last one served.
    always_comb begin
        w_c1  = f_next(r_ptr);
        w_c2  = f_next(w_c1);
        w_c3  = f_next(w_c2);
        w_any = |w_miss;
        if (w_miss[w_c1])      w_pick = w_c1;
        else if (w_miss[w_c2]) w_pick = w_c2;
        else                   w_pick = w_c3;
        case (w_pick)
            2'd0:    w_base = OFFSET0;
            2'd1:    w_base = OFFSET1;
            default: w_base = OFFSET2;
        endcase
        w_sdaddr_nxt = w_base + SAW'({w_addr[w_pick], 1'b0});
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any)     w_state_nxt = S_REQ;
            S_REQ:   if (sdram_ack) w_state_nxt = data_rdy ? S_W1 : S_W0;
            S_W0:    if (data_rdy)  w_state_nxt = S_W1;
            S_W1:    if (data_rdy)  w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= '0;
            r_ok     <= '0;
            r_ptr    <= 2'd2;
            r_slot   <= 2'd0;
            r_addr   <= '0;
            r_low    <= '0;
            r_req    <= 1'b0;
            r_sdaddr <= '0;
            for (int i = 0; i < 3; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            r_ok <= w_hit;
            case (r_state)
                S_IDLE: if (w_any) begin
                    r_slot   <= w_pick;
                    r_addr   <= w_addr[w_pick];
                    r_ptr    <= w_pick;
                    r_req    <= 1'b1;
                    r_sdaddr <= w_sdaddr_nxt;
                end
                S_REQ: if (sdram_ack) begin
                    r_req <= 1'b0;
                    if (data_rdy) r_low <= data_read;
                end
                S_W0: if (data_rdy) r_low <= data_read;
                S_W1: if (data_rdy) begin
                    r_tag[r_slot]   <= r_addr;
                    r_data[r_slot]  <= {data_read, r_low};
                    r_valid[r_slot] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign slot0_ok   = r_ok[0];
    assign slot1_ok   = r_ok[1];
    assign slot2_ok   = r_ok[2];
    assign slot0_dout = r_data[0];
    assign slot1_dout = r_data[1];
    assign slot2_dout = r_data[2];
    assign sdram_req  = r_req;
    assign sdram_addr = r_sdaddr;

endmodule
`default_nettype wire
